// File: rtl/dice_roll_checker_if.sv
// Bundle between the dice-roll checker and whoever drives and observes it:
// control and readout plus the roller's display lines.
interface dice_roll_checker_if #(
    parameter int HIST_W = 16
);
    logic              start;
    logic              clear;
    logic [6:0]        seg_in;
    logic              dp_in;
    logic [2:0]        hist_sel;
    logic              roll_out;
    logic              busy;
    logic [2:0]        value;
    logic              value_valid;
    logic [1:0]        err_code;
    logic [HIST_W-1:0] hist_count;

    modport master (
        output start, clear, seg_in, dp_in, hist_sel,
        input  roll_out, busy, value, value_valid, err_code, hist_count
    );

    modport slave (
        input  start, clear, seg_in, dp_in, hist_sel,
        output roll_out, busy, value, value_valid, err_code, hist_count
    );
endinterface

// File: rtl/dice_roll_checker.sv
// Presses the dice roller's button, follows its decimal point through roll and
// settle, decodes the settled 7-segment face and keeps per-face histograms.
module dice_roll_checker #(
    parameter int PRESS_CYCLES  = 2048,
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT       = 1000000,
    parameter int HIST_W        = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    dice_roll_checker_if.slave   bus
);

    localparam int PRESS_W  = $clog2(PRESS_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W     = 24;
    localparam logic [HIST_W-1:0] HIST_MAX = {HIST_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_SETTLE,
        ST_CAPTURE
    } state_t;

    state_t              state_reg;
    logic [6:0]          seg_s1_reg;
    logic [6:0]          seg_s2_reg;
    logic [6:0]          seg_prev_reg;
    logic                dp_s1_reg;
    logic                dp_s2_reg;
    logic [PRESS_W-1:0]  press_cnt_reg;
    logic [TO_W-1:0]     timeout_cnt_reg;
    logic [SETTLE_W-1:0] stable_cnt_reg;
    logic                roll_out_reg;
    logic                busy_reg;
    logic [2:0]          value_reg;
    logic                value_valid_reg;
    logic [1:0]          err_code_reg;
    logic [2:0]          cap_face_reg;
    logic                cap_ok_reg;
    logic [HIST_W-1:0]   total_reg;
    logic [HIST_W-1:0]   hist_count_reg;
    logic [HIST_W-1:0]   hist_val [6];

    logic [2:0] dec_face;
    logic       dec_ok;
    logic       press_done;
    logic       timeout_hit;
    logic       settle_done;
    logic       hist_inc;

    // Only the six legal faces decode; everything else is reported as bad.
    always_comb begin
        dec_face = 3'd0;
        dec_ok   = 1'b1;
        case (seg_s2_reg)
            7'b0000110: dec_face = 3'd1;
            7'b1011011: dec_face = 3'd2;
            7'b1001111: dec_face = 3'd3;
            7'b1100110: dec_face = 3'd4;
            7'b1101101: dec_face = 3'd5;
            7'b1111101: dec_face = 3'd6;
            default:    dec_ok   = 1'b0;
        endcase
    end

    assign press_done  = (press_cnt_reg == '0);
    assign timeout_hit = (timeout_cnt_reg == TO_W'(TIMEOUT - 1));
    assign settle_done = (stable_cnt_reg == SETTLE_W'(SETTLE_CYCLES - 1));
    assign hist_inc    = (state_reg == ST_CAPTURE) && cap_ok_reg && !bus.clear;

    // Roller outputs are asynchronous to us; seg_prev tracks the synced copy
    // every cycle so SETTLE can spot any change against the previous cycle.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_reg   <= '0;
            seg_s2_reg   <= '0;
            seg_prev_reg <= '0;
            dp_s1_reg    <= 1'b0;
            dp_s2_reg    <= 1'b0;
        end else begin
            seg_s1_reg   <= bus.seg_in;
            seg_s2_reg   <= seg_s1_reg;
            seg_prev_reg <= seg_s2_reg;
            dp_s1_reg    <= bus.dp_in;
            dp_s2_reg    <= dp_s1_reg;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            press_cnt_reg   <= '0;
            timeout_cnt_reg <= '0;
            stable_cnt_reg  <= '0;
            roll_out_reg    <= 1'b0;
            busy_reg        <= 1'b0;
            value_reg       <= 3'd0;
            value_valid_reg <= 1'b0;
            err_code_reg    <= 2'd0;
            cap_face_reg    <= 3'd0;
            cap_ok_reg      <= 1'b0;
        end else begin
            value_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg     <= ST_PRESS;
                        press_cnt_reg <= PRESS_W'(PRESS_CYCLES - 1);
                        roll_out_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_PRESS: begin
                    if (press_done) begin
                        roll_out_reg    <= 1'b0;
                        timeout_cnt_reg <= '0;
                        state_reg       <= ST_WAIT_LOW;
                    end else begin
                        press_cnt_reg <= press_cnt_reg - 1'b1;
                    end
                end
                ST_WAIT_LOW: begin
                    if (!dp_s2_reg) begin
                        timeout_cnt_reg <= '0;
                        state_reg       <= ST_WAIT_HIGH;
                    end else if (timeout_hit) begin
                        err_code_reg <= 2'd1;
                        busy_reg     <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (dp_s2_reg) begin
                        stable_cnt_reg <= '0;
                        state_reg      <= ST_SETTLE;
                    end else if (timeout_hit) begin
                        err_code_reg <= 2'd1;
                        busy_reg     <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!dp_s2_reg) begin
                        timeout_cnt_reg <= '0;
                        state_reg       <= ST_WAIT_HIGH;
                    end else if (seg_s2_reg != seg_prev_reg) begin
                        stable_cnt_reg <= '0;
                    end else if (settle_done) begin
                        // value/value_valid are presented during CAPTURE itself;
                        // the counters commit on the way out so clear can win.
                        cap_face_reg <= dec_face;
                        cap_ok_reg   <= dec_ok;
                        if (dec_ok) begin
                            value_reg       <= dec_face;
                            value_valid_reg <= 1'b1;
                        end
                        state_reg <= ST_CAPTURE;
                    end else begin
                        stable_cnt_reg <= stable_cnt_reg + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (!cap_ok_reg) begin
                        err_code_reg <= 2'd2;
                    end
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    roll_out_reg <= 1'b0;
                    busy_reg     <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase
            if (bus.clear) begin
                err_code_reg <= 2'd0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_hist
            logic [HIST_W-1:0] cnt_reg;

            always_ff @(posedge wb_clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (bus.clear) begin
                    cnt_reg <= '0;
                end else if (hist_inc && cap_face_reg == 3'(gi + 1) && cnt_reg != HIST_MAX) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign hist_val[gi] = cnt_reg;
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            total_reg <= '0;
        end else if (bus.clear) begin
            total_reg <= '0;
        end else if (hist_inc && total_reg != HIST_MAX) begin
            total_reg <= total_reg + 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            hist_count_reg <= '0;
        end else begin
            case (bus.hist_sel)
                3'd1:    hist_count_reg <= hist_val[0];
                3'd2:    hist_count_reg <= hist_val[1];
                3'd3:    hist_count_reg <= hist_val[2];
                3'd4:    hist_count_reg <= hist_val[3];
                3'd5:    hist_count_reg <= hist_val[4];
                3'd6:    hist_count_reg <= hist_val[5];
                default: hist_count_reg <= total_reg;
            endcase
        end
    end

    assign bus.roll_out    = roll_out_reg;
    assign bus.busy        = busy_reg;
    assign bus.value       = value_reg;
    assign bus.value_valid = value_valid_reg;
    assign bus.err_code    = err_code_reg;
    assign bus.hist_count  = hist_count_reg;

endmodule

// File: tb/tb_dice_roll_checker.sv
// Randomised rolls against a transaction-level model of the checker: expected
// histograms, error code and last face, plus timing rules for each roll.
module tb_dice_roll_checker;

    localparam int PRESS_CYCLES  = 40;
    localparam int SETTLE_CYCLES = 16;
    localparam int TIMEOUT       = 300;
    localparam int HIST_W        = 4;
    localparam int HMAX          = (1 << HIST_W) - 1;

    logic wb_clk_i = 1'b0;
    logic rst_n    = 1'b0;
    int   cyc      = 0;

    dice_roll_checker_if #(.HIST_W(HIST_W)) bus ();

    dice_roll_checker #(
        .PRESS_CYCLES (PRESS_CYCLES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .TIMEOUT      (TIMEOUT),
        .HIST_W       (HIST_W)
    ) dut (
        .wb_clk_i(wb_clk_i),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;
    always @(posedge wb_clk_i) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // model state
    int m_hist [1:6];
    int m_total;
    int m_err;
    int m_value;

    bit         chk_en   = 1'b0;
    bit         chk_prev = 1'b0;
    logic [2:0] sel_last = 3'd0;

    function automatic void check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic logic [6:0] pat_of(int f);
        case (f)
            1:       return 7'b0000110;
            2:       return 7'b1011011;
            3:       return 7'b1001111;
            4:       return 7'b1100110;
            5:       return 7'b1101101;
            default: return 7'b1111101;
        endcase
    endfunction

    function automatic int face_of(logic [6:0] p);
        for (int f = 1; f <= 6; f++) begin
            if (pat_of(f) == p) return f;
        end
        return 0;
    endfunction

    function automatic int model_count(logic [2:0] s);
        if (s >= 3'd1 && s <= 3'd6) return m_hist[int'(s)];
        return m_total;
    endfunction

    function automatic int sat_inc(int x);
        return (x < HMAX) ? x + 1 : HMAX;
    endfunction

    task automatic model_clear();
        for (int f = 1; f <= 6; f++) m_hist[f] = 0;
        m_total = 0;
        m_err   = 0;
    endtask

    // Per-cycle compare against the model while the bench holds a quiet window.
    always @(negedge wb_clk_i) begin
        if (rst_n && chk_en && chk_prev) begin
            check("hist_count", int'(bus.hist_count), model_count(sel_last));
            check("err_code", int'(bus.err_code), m_err);
            check("value", int'(bus.value), m_value);
        end
        chk_prev = chk_en;
        sel_last = bus.hist_sel;
    end

    task automatic tick();
        @(posedge wb_clk_i);
        #2;
    endtask

    task automatic idle_window(int n);
        chk_en = 1'b1;
        repeat (n) begin
            bus.hist_sel = 3'($urandom_range(0, 7));
            tick();
        end
        chk_en = 1'b0;
        tick();
    endtask

    task automatic read_hist(input int sel, output int v);
        bus.hist_sel = 3'(sel);
        tick();
        tick();
        v = int'(bus.hist_count);
    endtask

    // mode: 0 plain, 1 segment toggles while settling, 2 dp glitch while settling,
    //       3 dp never falls (timeout), 4 clear asserted during the capture cycle
    task automatic do_roll(input logic [6:0] pat, input int mode, input bit busy_start);
        int n, t_fall, t_last, t_busy, vv_cnt, vv_lat, vv_val, f;
        logic [6:0] other;
        f      = face_of(pat);
        vv_cnt = 0;
        vv_lat = 0;
        vv_val = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.roll_out && n < PRESS_CYCLES + 20) begin
            n++;
            tick();
        end
        check("press_len", n, PRESS_CYCLES);
        t_fall = cyc;
        if (busy_start) begin
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        if (mode == 3) begin
            n = 0;
            while (bus.busy && n < TIMEOUT + 50) begin
                n++;
                tick();
            end
            check("timeout_len", cyc - t_fall, TIMEOUT);
            check("timeout_busy", int'(bus.busy), 0);
            m_err = 1;
            return;
        end
        repeat ($urandom_range(0, 15)) tick();
        bus.dp_in = 1'b0;
        repeat ($urandom_range(3, 25)) begin
            bus.seg_in = 7'($urandom);
            tick();
        end
        if (mode == 1) begin
            other = pat ^ 7'b1000001;
            bus.dp_in  = 1'b1;
            bus.seg_in = other;
            repeat (10) tick();
            for (int k = 0; k < 2; k++) begin
                bus.seg_in = pat;
                repeat (10) tick();
                bus.seg_in = other;
                repeat (10) tick();
            end
        end else if (mode == 2) begin
            bus.dp_in  = 1'b1;
            bus.seg_in = pat;
            repeat (6) tick();
            bus.dp_in = 1'b0;
            repeat (4) tick();
        end
        bus.dp_in  = 1'b1;
        bus.seg_in = pat;
        t_last = cyc;
        n = 0;
        while (bus.busy && n < SETTLE_CYCLES + 40) begin
            tick();
            n++;
            if (bus.value_valid) begin
                vv_cnt++;
                vv_lat = cyc - t_last;
                vv_val = int'(bus.value);
                if (mode == 4) bus.clear = 1'b1;
            end else begin
                bus.clear = 1'b0;
            end
        end
        bus.clear = 1'b0;
        t_busy = cyc;
        check("busy_end", int'(bus.busy), 0);
        check("busy_fall_latency", t_busy - t_last, SETTLE_CYCLES + 4);
        check("vv_count", vv_cnt, (f != 0) ? 1 : 0);
        if (f != 0) begin
            check("vv_latency", vv_lat, SETTLE_CYCLES + 3);
            check("vv_value", vv_val, f);
        end
        if (mode == 4) begin
            model_clear();
            if (f != 0) m_value = f;
        end else if (f != 0) begin
            m_hist[f] = sat_inc(m_hist[f]);
            m_total   = sat_inc(m_total);
            m_value   = f;
        end else begin
            m_err = 2;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v, f, mode;
        logic [6:0] p;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        bus.seg_in   = 7'b0000110;
        bus.dp_in    = 1'b1;
        bus.hist_sel = 3'd0;
        model_clear();
        m_value = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_roll_out", int'(bus.roll_out), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_value", int'(bus.value), 0);
        check("rst_value_valid", int'(bus.value_valid), 0);
        check("rst_err_code", int'(bus.err_code), 0);
        check("rst_hist_count", int'(bus.hist_count), 0);
        rst_n = 1'b1;
        tick();

        // first roll, face 4
        do_roll(pat_of(4), 0, 1'b0);
        read_hist(4, v);
        check("hist4_first", v, 1);
        read_hist(0, v);
        check("total_first", v, 1);
        check("value_first", int'(bus.value), 4);
        idle_window(6);

        // faces cycling 1..6 with assorted settle behaviour and ignored starts
        for (int i = 0; i < 12; i++) begin
            do_roll(pat_of(i % 6 + 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            idle_window(4);
        end
        read_hist(7, v);
        check("total_after_cycle", v, 13);

        // timeout, then a successful roll keeps the sticky error
        do_roll(pat_of(5), 3, 1'b1);
        check("err_timeout", int'(bus.err_code), 1);
        idle_window(4);
        do_roll(pat_of(6), 0, 1'b0);
        check("err_sticky", int'(bus.err_code), 1);
        idle_window(4);

        // bad settled patterns
        do_roll(7'b0111111, 0, 1'b0);
        check("err_bad", int'(bus.err_code), 2);
        idle_window(4);
        do_roll(7'b0000111, 1, 1'b0);
        idle_window(4);

        // clear coincident with capture of face 3
        do_roll(pat_of(3), 4, 1'b0);
        read_hist(3, v);
        check("hist3_cleared", v, 0);
        read_hist(0, v);
        check("total_cleared", v, 0);
        check("value_after_clear", int'(bus.value), 3);
        check("err_after_clear", int'(bus.err_code), 0);
        idle_window(4);

        // saturation with a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            do_roll(pat_of(2), 0, 1'b0);
        end
        read_hist(2, v);
        check("hist2_saturated", v, 15);
        read_hist(0, v);
        check("total_saturated", v, 15);
        idle_window(6);

        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        idle_window(6);

        // random rolls
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do p = 7'($urandom); while (face_of(p) != 0);
                mode = $urandom_range(0, 2);
            end else begin
                f    = $urandom_range(1, 6);
                p    = pat_of(f);
                mode = ($urandom_range(0, 14) == 0) ? 3 : (($urandom_range(0, 14) == 0) ? 4 : $urandom_range(0, 2));
            end
            do_roll(p, mode, 1'($urandom_range(0, 1)));
            idle_window(3);
        end

        // reset in the middle of PRESS
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        check("press_before_reset", int'(bus.roll_out), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_roll_out", int'(bus.roll_out), 0);
        check("async_rst_busy", int'(bus.busy), 0);
        model_clear();
        m_value = 0;
        tick();
        rst_n = 1'b1;
        tick();
        idle_window(8);
        read_hist(0, v);
        check("total_after_reset", v, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
